// File: rtl/shifter_arbiter_if.sv
// One requester's link to shifter_arbiter: operation request with grant, and a
// valid/ready response carrying the shifted result.
interface shifter_arbiter_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic         req;
    logic [N-1:0] in;
    logic [C-1:0] cnt;
    logic [1:0]   op;
    logic         gnt;
    logic         rsp_valid;
    logic [N-1:0] res;
    logic         rsp_ready;

    modport master (
        output req, in, cnt, op, rsp_ready,
        input  gnt, rsp_valid, res
    );

    modport slave (
        input  req, in, cnt, op, rsp_ready,
        output gnt, rsp_valid, res
    );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin sharing of an external combinational shift/rotate unit between two
// requesters; operands are staged onto sh_* and results held per requester.
module shifter_arbiter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic             clk,
    input  logic             rst,
    shifter_arbiter_if.slave ch0,
    shifter_arbiter_if.slave ch1,
    output logic [N-1:0]     sh_in,
    output logic [C-1:0]     sh_cnt,
    output logic [1:0]       sh_op,
    input  logic [N-1:0]     sh_out,
    output logic             idle
);
    typedef enum logic {RQ0 = 1'b0, RQ1 = 1'b1} rq_t;

    rq_t          stage_id;
    rq_t          last_gnt;
    logic         stage_valid;
    logic [1:0]   elig;
    logic [1:0]   gnt;
    logic [1:0]   rsp_valid;
    logic [N-1:0] res0;
    logic [N-1:0] res1;
    logic [N-1:0] win_in;
    logic [C-1:0] win_cnt;
    logic [1:0]   win_op;

    // A requester is blocked while its result is unread or its op is in the stage.
    always_comb begin
        elig[0] = ch0.req & ~rsp_valid[0] & ~(stage_valid & (stage_id == RQ0));
        elig[1] = ch1.req & ~rsp_valid[1] & ~(stage_valid & (stage_id == RQ1));
    end

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (elig[0] && (!elig[1] || (last_gnt == RQ1))) begin
                gnt[0] = 1'b1;
            end else if (elig[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_comb begin
        win_in  = ch0.in;
        win_cnt = ch0.cnt;
        win_op  = ch0.op;
        if (gnt[1]) begin
            win_in  = ch1.in;
            win_cnt = ch1.cnt;
            win_op  = ch1.op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_id    <= RQ0;
            last_gnt    <= RQ1;
            sh_in       <= '0;
            sh_cnt      <= '0;
            sh_op       <= '0;
        end else begin
            stage_valid <= |gnt;
            if (|gnt) begin
                sh_in    <= win_in;
                sh_cnt   <= win_cnt;
                sh_op    <= win_op;
                stage_id <= gnt[1] ? RQ1 : RQ0;
                last_gnt <= gnt[1] ? RQ1 : RQ0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid[0] <= 1'b0;
            res0         <= '0;
        end else if (stage_valid && (stage_id == RQ0)) begin
            rsp_valid[0] <= 1'b1;
            res0         <= sh_out;
        end else if (rsp_valid[0] && ch0.rsp_ready) begin
            rsp_valid[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid[1] <= 1'b0;
            res1         <= '0;
        end else if (stage_valid && (stage_id == RQ1)) begin
            rsp_valid[1] <= 1'b1;
            res1         <= sh_out;
        end else if (rsp_valid[1] && ch1.rsp_ready) begin
            rsp_valid[1] <= 1'b0;
        end
    end

    assign ch0.gnt       = gnt[0];
    assign ch1.gnt       = gnt[1];
    assign ch0.rsp_valid = rsp_valid[0];
    assign ch1.rsp_valid = rsp_valid[1];
    assign ch0.res       = res0;
    assign ch1.res       = res1;
    assign idle          = ~stage_valid & ~rsp_valid[0] & ~rsp_valid[1];
endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: behavioural shifter on sh_*, per-requester result
// queues filled at grant and drained at each response handshake.
module tb_shifter_arbiter;
    localparam int N = 16;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sh_in;
    logic [N-1:0] sh_out;
    logic [C-1:0] sh_cnt;
    logic [1:0]   sh_op;
    logic         idle;

    always #5 clk = ~clk;

    shifter_arbiter_if #(.N(N), .C(C)) ch0 ();
    shifter_arbiter_if #(.N(N), .C(C)) ch1 ();

    shifter_arbiter #(.N(N), .C(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .ch0    (ch0),
        .ch1    (ch1),
        .sh_in  (sh_in),
        .sh_cnt (sh_cnt),
        .sh_op  (sh_op),
        .sh_out (sh_out),
        .idle   (idle)
    );

    function automatic logic [N-1:0] shf(input logic [N-1:0] a, input logic [C-1:0] c,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return (a << c) | (a >> (N - int'(c)));
            2'b01:   return a << c;
            2'b10:   return (a >> c) | (a << (N - int'(c)));
            default: return a >> c;
        endcase
    endfunction

    always_comb sh_out = shf(sh_in, sh_cnt, sh_op);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];
    int           glog[$];

    // Scoreboard: push the model result on grant, compare on handshake.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            check("gnt_excl", 32'(ch0.gnt & ch1.gnt), 0);
            if (ch0.gnt) begin
                q0.push_back(shf(ch0.in, ch0.cnt, ch0.op));
                glog.push_back(0);
            end
            if (ch1.gnt) begin
                q1.push_back(shf(ch1.in, ch1.cnt, ch1.op));
                glog.push_back(1);
            end
            if (ch0.rsp_valid && ch0.rsp_ready) begin
                if (q0.size() == 0) check("sb0_pending", q0.size(), 1);
                else check("sb0_res", ch0.res, q0.pop_front());
            end
            if (ch1.rsp_valid && ch1.rsp_ready) begin
                if (q1.size() == 0) check("sb1_pending", q1.size(), 1);
                else check("sb1_res", ch1.res, q1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int who);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((who == 0 && ch0.gnt) || (who == 1 && ch1.gnt)) begin
                ok = 1;
                break;
            end
        end
        check($sformatf("wait_gnt%0d", who), 32'(ok), 1);
    endtask

    task automatic wait_rsp(input int who);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((who == 0 && ch0.rsp_valid) || (who == 1 && ch1.rsp_valid)) begin
                ok = 1;
                break;
            end
        end
        check($sformatf("wait_rsp%0d", who), 32'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (idle) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle", 32'(ok), 1);
    endtask

    logic [N-1:0] t_in  [4] = '{16'h00F0, 16'h0001, 16'h8000, 16'h1234};
    logic [C-1:0] t_cnt [4] = '{4'd4, 4'd1, 4'd15, 4'd0};
    logic [1:0]   t_op  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [N-1:0] t_exp [4] = '{16'h0F00, 16'h8000, 16'h0001, 16'h1234};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ch0.req = 1'b1; ch0.in = 16'h8001; ch0.cnt = 4'd1; ch0.op = 2'b00; ch0.rsp_ready = 1'b0;
        ch1.req = 1'b0; ch1.in = '0;       ch1.cnt = '0;   ch1.op = '0;    ch1.rsp_ready = 1'b0;
        #12;
        check("rst_idle", 32'(idle), 1);
        check("rst_gnt0", 32'(ch0.gnt), 0);
        check("rst_rv0", 32'(ch0.rsp_valid), 0);
        check("rst_sh_in", 32'(sh_in), 0);

        // Single request on requester 0
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("single_gnt0", 32'(ch0.gnt), 1);
        step();
        ch0.req = 1'b0;
        check("single_sh_in", 32'(sh_in), 32'h8001);
        check("single_rv0_e0", 32'(ch0.rsp_valid), 0);
        step();
        check("single_rv0_e1", 32'(ch0.rsp_valid), 1);
        check("single_res0", 32'(ch0.res), 32'h0003);
        ch0.rsp_ready = 1'b1;
        step();
        check("single_rv0_clr", 32'(ch0.rsp_valid), 0);
        check("single_res0_hold", 32'(ch0.res), 32'h0003);
        check("single_idle", 32'(idle), 1);

        // Each operation on requester 1
        ch1.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            ch1.req = 1'b1; ch1.in = t_in[k]; ch1.cnt = t_cnt[k]; ch1.op = t_op[k];
            wait_gnt(1);
            step();
            ch1.req = 1'b0;
            wait_rsp(1);
            check($sformatf("op%0d_res1", k), 32'(ch1.res), 32'(t_exp[k]));
            step();
            check($sformatf("op%0d_rv1_clr", k), 32'(ch1.rsp_valid), 0);
        end
        wait_idle();

        // Contention: both held, alternation from requester 0
        step();
        glog.delete();
        ch0.req = 1'b1; ch0.in = 16'h00F1; ch0.cnt = 4'd3; ch0.op = 2'b01;
        ch1.req = 1'b1; ch1.in = 16'hF00F; ch1.cnt = 4'd2; ch1.op = 2'b10;
        repeat (9) @(posedge clk);
        #1;
        ch0.req = 1'b0;
        ch1.req = 1'b0;
        check("cont_count", 32'(glog.size() >= 6), 1);
        for (int k = 0; k < 6; k++) check($sformatf("cont_order%0d", k), 32'(glog[k]), 32'(k % 2));
        wait_idle();

        // Backpressure on requester 0 while requester 1 keeps running
        step();
        ch0.rsp_ready = 1'b0;
        ch0.req = 1'b1; ch0.in = 16'h0F0F; ch0.cnt = 4'd4; ch0.op = 2'b00;
        wait_gnt(0);
        wait_rsp(0);
        check("bp_res0", 32'(ch0.res), 32'hF0F0);
        step();
        ch1.req = 1'b1; ch1.in = 16'h0003; ch1.cnt = 4'd1; ch1.op = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_gnt1_c%0d", i), 32'(ch1.gnt), 32'(i % 3 == 0));
            check($sformatf("bp_gnt0_c%0d", i), 32'(ch0.gnt), 0);
            check($sformatf("bp_res0_c%0d", i), 32'(ch0.res), 32'hF0F0);
            check($sformatf("bp_rv0_c%0d", i), 32'(ch0.rsp_valid), 1);
        end
        step();
        ch1.req = 1'b0;
        ch0.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_gnt0_early", 32'(ch0.gnt), 0);
        @(negedge clk);
        check("bp_release_gnt0", 32'(ch0.gnt), 1);
        step();
        ch0.req = 1'b0;
        wait_idle();

        // Back-to-back cross traffic
        step();
        ch0.req = 1'b1; ch0.in = 16'h1234; ch0.cnt = 4'd4; ch0.op = 2'b10;
        @(negedge clk);
        check("b2b_gnt0", 32'(ch0.gnt), 1);
        step();
        ch0.req = 1'b0;
        ch1.req = 1'b1; ch1.in = 16'h8421; ch1.cnt = 4'd3; ch1.op = 2'b11;
        check("b2b_c1_sh", {12'b0, sh_op, sh_cnt, sh_in}, {12'b0, 2'b10, 4'd4, 16'h1234});
        @(negedge clk);
        check("b2b_gnt1", 32'(ch1.gnt), 1);
        step();
        ch1.req = 1'b0;
        check("b2b_c2_sh", {12'b0, sh_op, sh_cnt, sh_in}, {12'b0, 2'b11, 4'd3, 16'h8421});
        check("b2b_rv0", 32'(ch0.rsp_valid), 1);
        check("b2b_rv1_early", 32'(ch1.rsp_valid), 0);
        step();
        check("b2b_rv1", 32'(ch1.rsp_valid), 1);
        wait_idle();

        // Reset mid-flight
        ch0.rsp_ready = 1'b0;
        ch1.rsp_ready = 1'b0;
        step();
        ch1.req = 1'b1; ch1.in = 16'h00FF; ch1.cnt = 4'd8; ch1.op = 2'b00;
        @(negedge clk);
        check("mid_gnt1", 32'(ch1.gnt), 1);
        step();
        ch1.req = 1'b0;
        ch0.req = 1'b1; ch0.in = 16'h0101; ch0.cnt = 4'd1; ch0.op = 2'b01;
        @(negedge clk);
        check("mid_gnt0", 32'(ch0.gnt), 1);
        step();
        check("mid_rv1_pre", 32'(ch1.rsp_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rv0", 32'(ch0.rsp_valid), 0);
        check("mid_rst_rv1", 32'(ch1.rsp_valid), 0);
        check("mid_rst_sh", {12'b0, sh_op, sh_cnt, sh_in}, 0);
        check("mid_rst_idle", 32'(idle), 1);
        check("mid_rst_gnt0", 32'(ch0.gnt), 0);
        ch1.req = 1'b1;
        repeat (2) @(posedge clk);
        check("mid_rst_rv1_hold", 32'(ch1.rsp_valid), 0);
        ch0.rsp_ready = 1'b1;
        ch1.rsp_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("mid_tie_gnt0", 32'(ch0.gnt), 1);
        check("mid_tie_gnt1", 32'(ch1.gnt), 0);
        step();
        ch0.req = 1'b0;
        wait_gnt(1);
        step();
        ch1.req = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("end_q0_empty", q0.size(), 0);
        check("end_q1_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
